vram_wb_dp: RTL and testbench
=============================

Name: vram_wb_dp

Overview:
- Parametrised dual-port video RAM: Wishbone-style slave port for CPU read/write, independent read-only port for the VGA scanout engine.
- Adds what the fixed 11-bit VRAM lacks: configurable width and depth, byte-lane writes, out-of-range error response, deterministic read latency and a hardware clear engine.
- Sits between the CPU bus decoder and the VGA controller; one instance per text/attribute plane.

Parameters:
- DW, 16, data width in bits (multiple of 8).
- AW, 11, RAM address width.
- DEPTH, 1200, number of valid words (must be ≤ 2**AW).
- CLEAR_VAL, 0, word written to every location by the clear engine.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- dat_i  in  DW  write data.
- adr_i  in  32  byte address; word index = adr_i[AW+1:2].
- sel_i  in  DW/8  byte-lane write enables.
- we_i  in  1  1 = write, 0 = read.
- stb_i  in  1  transfer request, held until ack_o or err_o.
- dat_o  out  DW  read data, valid while ack_o is high.
- ack_o  out  1  one-cycle transfer-complete pulse.
- err_o  out  1  one-cycle pulse for an out-of-range index.
- vga_addr  in  AW  scanout word index.
- vga_dout  out  DW  scanout data.
- clr_req  in  1  pulse to start a fill with CLEAR_VAL.
- clr_busy  out  1  high while the clear engine runs.

Behaviour:
- Reset (asynchronous, rst=1):
  - State = IDLE.
  - ack_o, err_o, clr_busy, dat_o, vga_dout and the clear counter are all 0.
  - RAM contents are not reset.
- FSM states: IDLE, RD, RESP, CLR.
- IDLE, priority order:
  1. clr_req → CLR.
  2. stb_i with index ≥ DEPTH → RESP with err_o set. No RAM access; dat_o is unchanged.
  3. stb_i & we_i → write the RAM this cycle, masked per sel_i lane (lane k = bits 8k+7:8k). → RESP with ack_o set.
  4. stb_i & !we_i → present the address to the RAM → RD.
- RD:
  - If stb_i is still high: capture the RAM output into dat_o → RESP with ack_o set.
  - If stb_i dropped: abort → IDLE, with no ack.
- RESP:
  - ack_o or err_o is high for exactly this one cycle.
  - Next state is IDLE. A stb_i still high there is treated as a new transfer.
- Latency, stb_i rising to response pulse:
  - Write: 1 cycle.
  - Error: 1 cycle.
  - Read: 2 cycles.
- Throughput: at most one transfer per 2 cycles (writes) or 3 cycles (reads).
- CLR:
  - clr_busy = 1.
  - Writes CLEAR_VAL (all lanes) at counter address 0..DEPTH-1, one word per cycle.
  - After writing DEPTH-1: counter → 0, clr_busy → 0, state → IDLE. Total DEPTH cycles.
  - stb_i is stalled (no ack, no err) until clearing finishes, then served normally.
  - clr_req while busy is ignored. clr_req and stb_i in the same IDLE cycle: clear wins.
- Reset mid-clear: the clear aborts immediately. The partially cleared contents are left as-is.
- VGA port:
  - vga_dout = RAM[vga_addr] registered, 1-cycle latency, every cycle, unaffected by FSM state.
  - vga_addr ≥ DEPTH → vga_dout = 0 on the next cycle.
- Port collision: a CPU or clear write and a VGA read to the same address in the same cycle returns the old data on vga_dout (read-first).
- Width rules:
  - Address bits above AW+1 are ignored except through the DEPTH range check.
  - adr_i[1:0] is ignored.

Decomposition:
- Shared package vram_pkg holds:
  - the FSM state encoding (2-bit: IDLE, RD, RESP, CLR);
  - the function for the byte-lane count, DW/8;
  - the default constants for the text plane (DW=16, DEPTH=1200) and the attribute plane.
- One sub-module, vram_dp_bram:
  - inferred true dual-port RAM, parameters DW/AW/DEPTH;
  - port A: read/write with byte enables, registered read;
  - port B: read-only, read-first.
- Top-level module: FSM, range checks, clear counter and output registers only.

Test Plan:
- Write idx 5 = 0xBEEF with sel_i=11, then read idx 5 → ack_o 1 cycle after the write stb_i; the read ack arrives 2 cycles after its stb_i with dat_o=0xBEEF.
- Write idx 5 = 0x1234 with sel_i=01 over 0xBEEF; read → dat_o=0xBE34. Concurrent vga_addr=5 sees 0xBE34 one cycle after the write.
- Read at adr_i byte 4*1200 (index 1200, DEPTH=1200) → err_o pulses 1 cycle after stb_i; ack_o stays 0; dat_o keeps its previous value.
- clr_req asserted together with a write to idx 3 → clr_busy high for exactly 1200 cycles; the write acks after clr_busy falls. Afterwards: idx 3 reads back the written value, idx 0 and idx 1199 read 0.
- rst pulsed mid-clear at counter 600 → all outputs are 0 immediately. idx 0-599 read 0; idx 900 keeps its pre-clear value.
- VGA sweeps idx 0..1199 while the CPU writes the same address in the same cycle → vga_dout shows the old value that cycle and the new value on the next read of that address.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared definitions for the dual-port video RAM: FSM encoding, lane helper
// and the default geometry of the text and attribute planes.
package vram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_RESP = 2'd2,
    ST_CLR  = 2'd3
  } state_t;

  // Number of byte lanes in a word of width dw.
  function automatic int lane_count(input int dw);
    return dw / 8;
  endfunction

  localparam int VRAM_AW    = 11;
  localparam int TEXT_DW    = 16;
  localparam int TEXT_DEPTH = 1200;
  localparam int ATTR_DW    = 8;
  localparam int ATTR_DEPTH = 1200;

endpackage

// File: rtl/vram_dp_bram.sv
// Inferred dual-port RAM built from one 8-bit memory per byte lane.
// Port A: read/write with per-lane enables, registered read.
// Port B: read-only, registered, read-first against port A writes; an
// out-of-range port B address returns zero.
module vram_dp_bram
  import vram_pkg::*;
#(
  parameter int DW    = 16,
  parameter int AW    = 11,
  parameter int DEPTH = 1200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW/8-1:0]   we_a,
  input  logic [AW-1:0]     addr_a,
  input  logic [DW-1:0]     din_a,
  output logic [DW-1:0]     q_a,
  input  logic [AW-1:0]     addr_b,
  output logic [DW-1:0]     q_b
);

  localparam int            NL      = lane_count(DW);
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);

  logic a_ok;
  logic b_ok;

  // Guard both ports so a wide address never indexes past the array.
  assign a_ok = {1'b0, addr_a} < DEPTH_L;
  assign b_ok = {1'b0, addr_b} < DEPTH_L;

  genvar gi;
  generate
    for (gi = 0; gi < NL; gi++) begin : g_lane
      logic [7:0] mem [0:DEPTH-1];
      logic [7:0] qa_reg;
      logic [7:0] qb_reg;

      // Port A: lane write and registered read of the same location.
      always_ff @(posedge clk) begin
        if (a_ok) begin
          if (we_a[gi]) begin
            mem[addr_a] <= din_a[8*gi +: 8];
          end
          qa_reg <= mem[addr_a];
        end
      end

      // Port B: registered scanout read; sees the pre-write contents on a collision.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          qb_reg <= '0;
        end else if (b_ok) begin
          qb_reg <= mem[addr_b];
        end else begin
          qb_reg <= '0;
        end
      end

      assign q_a[8*gi +: 8] = qa_reg;
      assign q_b[8*gi +: 8] = qb_reg;
    end
  endgenerate

endmodule

// File: rtl/vram_wb_dp.sv
// Wishbone-style slave front end for the video RAM plus an independent
// scanout port and a hardware clear engine. Holds the transfer FSM, the
// range check, the clear counter and the output registers.
module vram_wb_dp
  import vram_pkg::*;
#(
  parameter int            DW        = TEXT_DW,
  parameter int            AW        = VRAM_AW,
  parameter int            DEPTH     = TEXT_DEPTH,
  parameter logic [DW-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     dat_i,
  input  logic [31:0]       adr_i,
  input  logic [DW/8-1:0]   sel_i,
  input  logic              we_i,
  input  logic              stb_i,
  output logic [DW-1:0]     dat_o,
  output logic              ack_o,
  output logic              err_o,
  input  logic [AW-1:0]     vga_addr,
  output logic [DW-1:0]     vga_dout,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam int            NL       = lane_count(DW);
  localparam logic [29:0]   DEPTH_W  = 30'(DEPTH);
  localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

  state_t            state_reg;
  logic [AW-1:0]     clr_cnt_reg;

  logic [AW-1:0]     word_idx;
  logic              in_range;
  logic [NL-1:0]     ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_din;
  logic [DW-1:0]     ram_q;
  logic              unused_adr;

  // The range check uses the full word index, so address bits above the RAM
  // width still turn an access into an error even though they never reach it.
  assign word_idx   = adr_i[AW+1:2];
  assign in_range   = adr_i[31:2] < DEPTH_W;
  assign unused_adr = ^adr_i[1:0];

  // Port A steering: the clear engine owns the RAM while it runs; otherwise a
  // CPU write lands in the IDLE cycle unless a clear request takes priority.
  always_comb begin
    ram_we   = '0;
    ram_addr = word_idx;
    ram_din  = dat_i;
    if (state_reg == ST_CLR) begin
      ram_we   = '1;
      ram_addr = clr_cnt_reg;
      ram_din  = CLEAR_VAL;
    end else if (state_reg == ST_IDLE && !clr_req && stb_i && in_range && we_i) begin
      ram_we = sel_i;
    end
  end

  vram_dp_bram #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_bram (
    .clk    (clk),
    .rst    (rst),
    .we_a   (ram_we),
    .addr_a (ram_addr),
    .din_a  (ram_din),
    .q_a    (ram_q),
    .addr_b (vga_addr),
    .q_b    (vga_dout)
  );

  // Transfer/clear FSM with registered response pulses and read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      ack_o       <= 1'b0;
      err_o       <= 1'b0;
      clr_busy    <= 1'b0;
      dat_o       <= '0;
      clr_cnt_reg <= '0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (clr_req) begin
            state_reg   <= ST_CLR;
            clr_busy    <= 1'b1;
            clr_cnt_reg <= '0;
          end else if (stb_i) begin
            if (!in_range) begin
              err_o     <= 1'b1;
              state_reg <= ST_RESP;
            end else if (we_i) begin
              ack_o     <= 1'b1;
              state_reg <= ST_RESP;
            end else begin
              state_reg <= ST_RD;
            end
          end
        end
        ST_RD: begin
          // A master that gave up during the RAM access gets no response.
          if (stb_i) begin
            dat_o     <= ram_q;
            ack_o     <= 1'b1;
            state_reg <= ST_RESP;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_RESP: begin
          state_reg <= ST_IDLE;
        end
        ST_CLR: begin
          if (clr_cnt_reg == CNT_LAST) begin
            clr_cnt_reg <= '0;
            clr_busy    <= 1'b0;
            state_reg   <= ST_IDLE;
          end else begin
            clr_cnt_reg <= clr_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_wb_dp.sv
// Randomised self-checking bench for vram_wb_dp against a word-array model.
module tb_vram_wb_dp;

  localparam int DW    = 16;
  localparam int AW    = 11;
  localparam int DEPTH = 1200;

  logic        clk;
  logic        rst;
  logic [15:0] dat_i;
  logic [31:0] adr_i;
  logic [1:0]  sel_i;
  logic        we_i;
  logic        stb_i;
  logic [15:0] dat_o;
  logic        ack_o;
  logic        err_o;
  logic [10:0] vga_addr;
  logic [15:0] vga_dout;
  logic        clr_req;
  logic        clr_busy;

  vram_wb_dp #(
    .DW        (DW),
    .AW        (AW),
    .DEPTH     (DEPTH),
    .CLEAR_VAL (16'h0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .dat_i    (dat_i),
    .adr_i    (adr_i),
    .sel_i    (sel_i),
    .we_i     (we_i),
    .stb_i    (stb_i),
    .dat_o    (dat_o),
    .ack_o    (ack_o),
    .err_o    (err_o),
    .vga_addr (vga_addr),
    .vga_dout (vga_dout),
    .clr_req  (clr_req),
    .clr_busy (clr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: RAM contents as plain words, plus the last returned read data.
  logic [15:0] mem_model [0:DEPTH-1];
  logic [15:0] dat_model;
  bit          vga_chk;
  int          n_checks;
  int          n_fail;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] vga_ref(input logic [10:0] a);
    if (int'(a) < DEPTH) return mem_model[a];
    return 16'h0000;
  endfunction

  // One clock; the scanout value seen after the edge is the model contents
  // before any write performed on that same edge.
  task automatic tick();
    logic [15:0] ve;
    ve = vga_ref(vga_addr);
    @(posedge clk);
    #1;
    if (vga_chk) check_eq("vga", 64'(vga_dout), 64'(ve));
  endtask

  function automatic void model_write(input int unsigned idx, input logic [15:0] data,
                                      input logic [1:0] sel);
    logic [15:0] mask;
    mask = {{8{sel[1]}}, {8{sel[0]}}};
    mem_model[idx] = (mem_model[idx] & ~mask) | (data & mask);
  endfunction

  // One bus transfer: latency, response type, data and single-cycle pulse.
  task automatic bus_xfer(input string tag, input logic [31:0] adr, input logic wr,
                          input logic [15:0] data, input logic [1:0] sel);
    int unsigned widx;
    bit          oor;
    int          exp_lat;
    int          cyc;
    bit          got;
    widx    = int'(adr[31:2]);
    oor     = (adr[31:2] >= 30'(DEPTH));
    exp_lat = (!oor && !wr) ? 2 : 1;
    adr_i = adr; we_i = wr; dat_i = data; sel_i = sel; stb_i = 1'b1;
    cyc = 0; got = 0;
    while (!got && cyc < 50) begin
      tick();
      cyc++;
      got = ack_o | err_o;
    end
    check_eq({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    check_eq({tag, "_ack"}, 64'(ack_o), 64'(!oor));
    check_eq({tag, "_err"}, 64'(err_o), 64'(oor));
    if (got && !oor) begin
      if (wr) model_write(widx, data, sel);
      else    dat_model = mem_model[widx];
    end
    check_eq({tag, "_dat"}, 64'(dat_o), 64'(dat_model));
    stb_i = 1'b0; we_i = 1'b0;
    tick();
    check_eq({tag, "_pulse"}, 64'({ack_o, err_o}), 64'(0));
  endtask

  // Start a clear and wait for it to finish; reports busy length and any response seen.
  task automatic run_clear(output int busy_cycles, output bit resp_during);
    vga_chk = 0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    busy_cycles = 0;
    resp_during = 0;
    while (clr_busy && busy_cycles < 1300) begin
      busy_cycles++;
      if (ack_o || err_o) resp_during = 1;
      tick();
    end
    if (ack_o || err_o) resp_during = 1;
    for (int i = 0; i < DEPTH; i++) mem_model[i] = 16'h0000;
    vga_chk = 1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          busy_n;
    bit          resp_seen;
    int unsigned idx;
    int          r;
    logic [31:0] adr;

    n_checks = 0; n_fail = 0; vga_chk = 0;
    rst = 1'b1; dat_i = '0; adr_i = '0; sel_i = '0; we_i = 0; stb_i = 0;
    vga_addr = 11'd5; clr_req = 0;
    for (int i = 0; i < DEPTH; i++) mem_model[i] = 16'h0000;
    dat_model = 16'h0000;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ack",  64'(ack_o),    64'(0));
    check_eq("rst_err",  64'(err_o),    64'(0));
    check_eq("rst_busy", 64'(clr_busy), 64'(0));
    check_eq("rst_dat",  64'(dat_o),    64'(0));
    check_eq("rst_vga",  64'(vga_dout), 64'(0));
    rst = 1'b0;

    // Bring the RAM to a known state.
    run_clear(busy_n, resp_seen);
    check_eq("init_clr_len", 64'(busy_n), 64'(DEPTH));

    // Full write then read-back.
    bus_xfer("tp1_wr", 32'd5 << 2, 1'b1, 16'hBEEF, 2'b11);
    bus_xfer("tp1_rd", 32'd5 << 2, 1'b0, 16'h0000, 2'b00);
    check_eq("tp1_val", 64'(dat_o), 64'(16'hBEEF));

    // Low-lane-only write with scanout watching the same word.
    vga_addr = 11'd5;
    bus_xfer("tp2_wr", 32'd5 << 2, 1'b1, 16'h1234, 2'b01);
    check_eq("tp2_vga", 64'(vga_dout), 64'(16'hBE34));
    bus_xfer("tp2_rd", 32'd5 << 2, 1'b0, 16'h0000, 2'b00);
    check_eq("tp2_val", 64'(dat_o), 64'(16'hBE34));

    // Out-of-range accesses, including through ignored-for-indexing high bits.
    bus_xfer("tp3_err", 32'd4800, 1'b0, 16'h0000, 2'b00);
    check_eq("tp3_keep", 64'(dat_o), 64'(16'hBE34));
    bus_xfer("tp3_hi", 32'h8000_0014, 1'b1, 16'h5555, 2'b11);
    bus_xfer("tp3_last_wr", 32'd1199 << 2 | 32'd3, 1'b1, 16'hA5C3, 2'b11);
    bus_xfer("tp3_last_rd", 32'd1199 << 2, 1'b0, 16'h0000, 2'b00);
    vga_addr = 11'd2047;

    // Read abandoned in the RD cycle: no response, data unchanged.
    adr_i = 32'd7 << 2; we_i = 1'b0; stb_i = 1'b1;
    tick();
    stb_i = 1'b0;
    tick();
    check_eq("abort_ack", 64'({ack_o, err_o}), 64'(0));
    tick();
    check_eq("abort_idle", 64'({ack_o, err_o}), 64'(0));
    check_eq("abort_dat", 64'(dat_o), 64'(dat_model));

    // Clear requested in the same cycle as a write: clear first, then the write.
    bus_xfer("tp4_pre3", 32'd3 << 2, 1'b1, 16'h7777, 2'b11);
    bus_xfer("tp4_pre0", 32'd0, 1'b1, 16'h1111, 2'b11);
    adr_i = 32'd3 << 2; we_i = 1'b1; dat_i = 16'hABCD; sel_i = 2'b11; stb_i = 1'b1;
    run_clear(busy_n, resp_seen);
    check_eq("tp4_clr_len", 64'(busy_n), 64'(DEPTH));
    check_eq("tp4_stall", 64'(resp_seen), 64'(0));
    tick();
    check_eq("tp4_wr_ack", 64'(ack_o), 64'(1));
    model_write(3, 16'hABCD, 2'b11);
    stb_i = 1'b0; we_i = 1'b0;
    tick();
    bus_xfer("tp4_rd3", 32'd3 << 2, 1'b0, 16'h0000, 2'b00);
    check_eq("tp4_val3", 64'(dat_o), 64'(16'hABCD));
    bus_xfer("tp4_rd0", 32'd0, 1'b0, 16'h0000, 2'b00);
    check_eq("tp4_val0", 64'(dat_o), 64'(0));
    bus_xfer("tp4_rd1199", 32'd1199 << 2, 1'b0, 16'h0000, 2'b00);
    check_eq("tp4_val1199", 64'(dat_o), 64'(0));

    // Reset in the middle of a clear, after locations 0..599 are written.
    bus_xfer("tp5_w0",   32'd0,        1'b1, 16'h1111, 2'b11);
    bus_xfer("tp5_w599", 32'd599 << 2, 1'b1, 16'h2222, 2'b11);
    bus_xfer("tp5_w600", 32'd600 << 2, 1'b1, 16'h3333, 2'b11);
    bus_xfer("tp5_w900", 32'd900 << 2, 1'b1, 16'h4444, 2'b11);
    vga_addr = 11'd900;
    bus_xfer("tp5_r900", 32'd900 << 2, 1'b0, 16'h0000, 2'b00);
    vga_chk = 0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (600) tick();
    check_eq("tp5_busy", 64'(clr_busy), 64'(1));
    rst = 1'b1;
    #1;
    check_eq("tp5_rst_out", 64'({ack_o, err_o, clr_busy}), 64'(0));
    check_eq("tp5_rst_dat", 64'(dat_o), 64'(0));
    check_eq("tp5_rst_vga", 64'(vga_dout), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 600; i++) mem_model[i] = 16'h0000;
    dat_model = 16'h0000;
    vga_chk = 1;
    bus_xfer("tp5_r0", 32'd0, 1'b0, 16'h0000, 2'b00);
    check_eq("tp5_val0", 64'(dat_o), 64'(0));
    bus_xfer("tp5_r599", 32'd599 << 2, 1'b0, 16'h0000, 2'b00);
    check_eq("tp5_val599", 64'(dat_o), 64'(0));
    bus_xfer("tp5_r600", 32'd600 << 2, 1'b0, 16'h0000, 2'b00);
    check_eq("tp5_val600", 64'(dat_o), 64'(16'h3333));
    bus_xfer("tp5_r900b", 32'd900 << 2, 1'b0, 16'h0000, 2'b00);
    check_eq("tp5_val900", 64'(dat_o), 64'(16'h4444));

    // Scanout sweep colliding with CPU writes to the same word every step.
    for (int i = 0; i < DEPTH; i++) begin
      vga_addr = 11'(i);
      bus_xfer("sweep", 32'(i) << 2, 1'b1, 16'($urandom), 2'b11);
    end

    // Random mix of reads, writes and out-of-range accesses.
    for (int t = 0; t < 300; t++) begin
      idx = $urandom_range(0, DEPTH - 1);
      r   = int'($urandom_range(0, 99));
      adr = (32'(idx) << 2) | 32'($urandom_range(0, 3));
      if (r < 8)       adr = 32'($urandom_range(DEPTH, 2047)) << 2;
      else if (r < 14) adr = adr | (32'($urandom_range(1, 1023)) << 22);
      vga_addr = ($urandom_range(0, 2) == 0) ? 11'(idx) : 11'($urandom_range(0, 2047));
      bus_xfer("rnd", adr, 1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
